mdu_sequencer: RTL

Multi-cycle unsigned multiply/divide sequencer for the EX stage. It performs MUL, MULHU, DIVU and REMU by driving the shared 32-bit ALU with ADD/SUB operations for 32 iterations. It holds the pipeline stalled while busy and returns a registered result with a one-cycle done pulse. The ALU remains a separate instance; this block owns its Operation/SrcA/SrcB inputs whenever it is busy.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer and the ALU decoder.
// No logic; the enums and ALU opcodes are imported by mdu_sequencer.
// The ALU opcodes must match the values the ALU decoder uses.
package mdu_pkg;

   // Operation select, encoded exactly as the op input
   typedef enum logic [1:0] {
      MUL   = 2'b00,
      MULHU = 2'b01,
      DIVU  = 2'b10,
      REMU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } mdu_state_e;

   localparam logic [3:0] ALU_OP_ADD = 4'b0010;
   localparam logic [3:0] ALU_OP_SUB = 4'b0110;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer driving the shared ALU with ADD/SUB.
// Latency: 34 cycles start-to-idle (done in cycle 33); divide-by-zero finishes in cycle 1.
// Optional MDU_EARLY_OUT_EN: MUL/MULHU with a zero operand also finishes in cycle 1.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [DATA_WIDTH-1:0]    a,
   input  logic [DATA_WIDTH-1:0]    b,
   output logic                     busy,
   output logic                     stall,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    result,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   output logic [DATA_WIDTH-1:0]    alu_a,
   output logic [DATA_WIDTH-1:0]    alu_b,
   input  logic [DATA_WIDTH-1:0]    alu_result
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   mdu_state_e            state_q;
   mdu_op_e               op_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] acc_hi_q, acc_lo_q;
   logic [DATA_WIDTH-1:0] acc_hi_d, acc_lo_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]         cnt_q;

   logic                  is_div;
   logic [DATA_WIDTH-1:0] div_shift;
   logic                  q_bit;
   logic                  carry;
   logic                  zero_short;

   assign is_div = op_q[1];
   assign busy   = (state_q != IDLE);
   assign stall  = busy | (start & (state_q == IDLE));
   assign done   = (state_q == DONE);
   assign result = result_q;

   // Divisor zero always short-circuits; a zero multiply operand only with the early-out build
`ifdef MDU_EARLY_OUT_EN
   assign zero_short = op[1] ? (b == '0) : ((a == '0) | (b == '0));
`else
   assign zero_short = op[1] & (b == '0);
`endif

   // One iteration of shift-add multiply or restoring divide through the external ALU
   always_comb begin
      alu_op    = '0;
      alu_a     = '0;
      alu_b     = '0;
      div_shift = {acc_hi_q[DATA_WIDTH-2:0], acc_lo_q[DATA_WIDTH-1]};
      q_bit     = 1'b0;
      carry     = 1'b0;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      if (state_q == CALC) begin
         if (is_div) begin
            alu_op   = OPCODE_LENGTH'(ALU_OP_SUB);
            alu_a    = div_shift;
            alu_b    = b_q;
            // A bit shifted out of acc_hi means the partial remainder already exceeds b;
            // the wrapped 32-bit difference is then the correct new remainder.
            q_bit    = acc_hi_q[DATA_WIDTH-1] | (div_shift >= b_q);
            acc_hi_d = q_bit ? alu_result : div_shift;
            acc_lo_d = {acc_lo_q[DATA_WIDTH-2:0], q_bit};
         end else begin
            alu_op   = OPCODE_LENGTH'(ALU_OP_ADD);
            alu_a    = acc_hi_q;
            alu_b    = acc_lo_q[0] ? b_q : '0;
            carry    = (alu_result < acc_hi_q);
            acc_hi_d = {carry, alu_result[DATA_WIDTH-1:1]};
            acc_lo_d = {alu_result[0], acc_lo_q[DATA_WIDTH-1:1]};
         end
      end
   end

   // Low word for MUL/DIVU, high word for MULHU/REMU, taken from the final iteration
   assign result_d = op_q[0] ? acc_hi_d : acc_lo_d;

   // Sequencer FSM, iteration counter, accumulators and registered result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q     <= mdu_op_e'(op);
                  b_q      <= b;
                  acc_hi_q <= '0;
                  acc_lo_q <= a;
                  cnt_q    <= '0;
                  if (zero_short) begin
                     state_q <= DONE;
                     if (op[1])
                        result_q <= op[0] ? a : '1;
                     else
                        result_q <= '0;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_hi_q <= acc_hi_d;
               acc_lo_q <= acc_lo_d;
               if (cnt_q == CNT_LAST) begin
                  state_q  <= DONE;
                  result_q <= result_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
